// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: one-hot phase in, blanked digit enables and hex segments out.
// Optional LEADING_ZERO_BLANK_EN: suppress segments of digits above the highest nonzero nibble.
module seg_scan_driver #(
  parameter int DIGITS       = 5,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     phase,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic                  data_valid,
  output logic [DIGITS-1:0]     an_out,
  output logic [7:0]            seg_out,
  output logic                  frame_done,
  output logic                  phase_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam int CW = 10;
  localparam logic [CW-1:0]     BLANK_N = CW'(BLANK_CYCLES);
  localparam logic [DIGITS-1:0] LAST    = {1'b1, {(DIGITS-1){1'b0}}};
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [DIGITS-1:0]   phase_q;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, frame_buf_q, frame_buf_d;
  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;
  logic                phase_err_q, phase_err_d;
  logic [DIGITS-1:0]   show_d;
  logic                step, onehot, frame_start;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   an_raw;
  logic [7:0]          seg_raw;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] show_q;
  logic              nz_acc;
`endif

  always_comb begin
    step        = (phase != phase_q);
    onehot      = (phase != '0) && ((phase & (phase - 1'b1)) == '0);
    frame_start = step && onehot && phase[0];

    shadow_d    = data_valid ? disp_data : shadow_q;
    frame_buf_d = frame_buf_q;
    if (frame_start) frame_buf_d = data_valid ? disp_data : shadow_q;

    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_err_d  = phase_err_q;
    frame_done_d = frame_start && (phase_q == LAST);
    if (step && !onehot) begin
      state_d     = S_IDLE;
      phase_err_d = 1'b1;
    end else if (step) begin
      state_d = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
      cnt_d   = {{(CW-1){1'b0}}, 1'b1};
    end else if (state_q == S_BLANK) begin
      if (cnt_q == BLANK_N) state_d = S_DRIVE;
      else                  cnt_d   = cnt_q + 1'b1;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Mask is decided once per frame so digits never flicker mid-scan.
    show_d = show_q;
    nz_acc = 1'b0;
    if (frame_start) begin
      for (int i = DIGITS-1; i >= 0; i--) begin
        nz_acc    = nz_acc | (|frame_buf_d[4*i +: 4]);
        show_d[i] = nz_acc || (i == 0);
      end
    end
`else
    show_d = {DIGITS{1'b1}};
`endif

    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (phase[i]) nib = nib | frame_buf_d[4*i +: 4];

    an_raw  = (state_d == S_DRIVE) ? phase : '0;
    seg_raw = ((state_d == S_DRIVE) && |(phase & show_d)) ? {1'b0, hex7(nib)} : 8'h00;
    an_d    = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
    seg_d   = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      shadow_q     <= '0;
      frame_buf_q  <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
      phase_err_q  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      show_q       <= {{(DIGITS-1){1'b0}}, 1'b1};
`endif
    end else begin
      phase_q      <= phase;
      shadow_q     <= shadow_d;
      frame_buf_q  <= frame_buf_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      phase_err_q  <= phase_err_d;
`ifdef LEADING_ZERO_BLANK_EN
      show_q       <= show_d;
`endif
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign frame_done = frame_done_q;
  assign phase_err  = phase_err_q;
endmodule
